// File: rtl/btb_update_unit_pkg.sv
// Shared LC-3b types used by the BTB write-side controller.
//   btb_tag / btb_index : BTB tag and set index slices of a PC
//   btb_update_req      : one resolved-branch report as held in the FIFO
//   btb_upd_action      : what a report does to the BTB
//   btb_upd_state       : controller state (IDLE / SWEEP)
//   classify()          : report -> action decision
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [10:0] btb_tag;
  typedef logic [3:0]  btb_index;

  typedef struct packed {
    btb_tag   tag;
    btb_index index;
    lc3b_word target;
    logic     taken;
    logic     hit;
    logic     predicted;
  } btb_update_req;

  typedef enum logic [1:0] {DROP, ALLOC, CORRECT} btb_upd_action;

  typedef enum logic {IDLE, SWEEP} btb_upd_state;

  // A miss only matters if the branch was taken; a hit only matters if the
  // prediction was wrong.
  function automatic btb_upd_action classify(btb_update_req r);
    if (r.hit) return (r.taken != r.predicted) ? CORRECT : DROP;
    return r.taken ? ALLOC : DROP;
  endfunction

endpackage

// File: rtl/btb_update_unit_fifo.sv
// btb_update_fifo: synchronous FIFO of btb_update_req.
//   push/din  : write din when not full
//   pop       : advance head when not empty
//   clear     : drop all contents (takes priority over push/pop)
//   full/empty: status; head: oldest entry (valid when !empty)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module btb_update_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  btb_update_req din,
  output logic          full,
  output logic          empty,
  output btb_update_req head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wp_q, rp_q;
  btb_update_req mem_q [DEPTH];

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q == {~rp_q[AW], rp_q[AW-1:0]});
  assign head  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push && !full) wp_q <= wp_q + (AW+1)'(1);
      if (pop && !empty) rp_q <= rp_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/btb_update_unit.sv
// btb_update_unit: write-side controller of the branch target buffer.
// Buffers resolved-branch reports, turns each into an ALLOC / CORRECT / DROP
// write on the BTB write port, and sweeps every valid bit to 0 on flush_req.
//   res_*      : report handshake (accepted when res_valid & res_ready)
//   flush_req  : single-cycle full-table invalidate request
//   busy       : high exactly while the FSM is in SWEEP (state visibility)
//   wr_addr, tag_out, bta_out, valid_out, predict_out : BTB write data
//   ld_valid, ld_tag, ld_data, ld_predict             : BTB write strobes
// Handshake: a report transfers on a rising edge where res_valid and
// res_ready are both high; res_ready does not depend on res_valid.
// Optional build macro BTB_UPDATE_RESET_SWEEP_EN: start a sweep right after
// reset so the BTB valid array needs no reset of its own.
module btb_update_unit
  import lc3b_types::*;
#(
  parameter int num_entries = 16,
  parameter int fifo_depth  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [15:0] res_pc,
  input  logic [15:0] res_target,
  input  logic        res_taken,
  input  logic        res_btb_hit,
  input  logic        res_predicted,
  input  logic        flush_req,
  output logic        busy,
  output logic [3:0]  wr_addr,
  output logic [10:0] tag_out,
  output logic [15:0] bta_out,
  output logic        valid_out,
  output logic        predict_out,
  output logic        ld_valid,
  output logic        ld_tag,
  output logic        ld_data,
  output logic        ld_predict
);

  localparam int CW = $clog2(num_entries);
  localparam logic [CW-1:0] LAST_IDX = CW'(num_entries - 1);

  btb_upd_state  state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  btb_index      wr_addr_q;
  btb_tag        tag_q;
  lc3b_word      bta_q;
  logic          valid_q, predict_q;
  logic          ld_valid_q, ld_tag_q, ld_data_q, ld_predict_q;

  btb_update_req req_in, head;
  btb_upd_action act;
  logic          fifo_full, fifo_empty;
  logic          idle, sweep_start, init_pend, pop;

  assign idle    = (state_q == IDLE);
  assign cnt_nxt = cnt_q + CW'(1);

`ifdef BTB_UPDATE_RESET_SWEEP_EN
  // Set by reset, consumed by the first IDLE cycle, which launches a sweep.
  logic init_q;
  assign init_pend = init_q;
`else
  assign init_pend = 1'b0;
`endif

  assign sweep_start = flush_req | init_pend;
  assign res_ready   = !fifo_full && idle && !init_pend;
  assign pop         = idle && !fifo_empty && !sweep_start;

  assign req_in = '{tag:       res_pc[15:5],
                    index:     res_pc[4:1],
                    target:    res_target,
                    taken:     res_taken,
                    hit:       res_btb_hit,
                    predicted: res_predicted};

  btb_update_fifo #(.DEPTH(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_valid && res_ready),
    .pop   (pop),
    .clear (idle && sweep_start),
    .din   (req_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign act = classify(head);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      tag_q        <= '0;
      bta_q        <= '0;
      valid_q      <= 1'b0;
      predict_q    <= 1'b0;
      ld_valid_q   <= 1'b0;
      ld_tag_q     <= 1'b0;
      ld_data_q    <= 1'b0;
      ld_predict_q <= 1'b0;
`ifdef BTB_UPDATE_RESET_SWEEP_EN
      init_q       <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle; data registers hold unless rewritten.
      ld_valid_q   <= 1'b0;
      ld_tag_q     <= 1'b0;
      ld_data_q    <= 1'b0;
      ld_predict_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sweep_start) begin
            // Starting the sweep replaces whatever write the head would give.
            state_q    <= SWEEP;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            ld_valid_q <= 1'b1;
            valid_q    <= 1'b0;
`ifdef BTB_UPDATE_RESET_SWEEP_EN
            init_q     <= 1'b0;
`endif
          end else if (pop) begin
            case (act)
              ALLOC: begin
                wr_addr_q    <= head.index;
                tag_q        <= head.tag;
                bta_q        <= head.target;
                valid_q      <= 1'b1;
                predict_q    <= 1'b1;
                ld_valid_q   <= 1'b1;
                ld_tag_q     <= 1'b1;
                ld_data_q    <= 1'b1;
                ld_predict_q <= 1'b1;
              end
              CORRECT: begin
                wr_addr_q    <= head.index;
                predict_q    <= head.taken;
                ld_predict_q <= 1'b1;
                if (head.taken) begin
                  bta_q     <= head.target;
                  ld_data_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        SWEEP: begin
          if (flush_req) begin
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            ld_valid_q <= 1'b1;
            valid_q    <= 1'b0;
          end else if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
          end else begin
            cnt_q      <= cnt_nxt;
            wr_addr_q  <= btb_index'(cnt_nxt);
            ld_valid_q <= 1'b1;
            valid_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == SWEEP);
  assign wr_addr     = wr_addr_q;
  assign tag_out     = tag_q;
  assign bta_out     = bta_q;
  assign valid_out   = valid_q;
  assign predict_out = predict_q;
  assign ld_valid    = ld_valid_q;
  assign ld_tag      = ld_tag_q;
  assign ld_data     = ld_data_q;
  assign ld_predict  = ld_predict_q;

endmodule

// File: tb/tb_btb_update_unit.sv
// Bench for btb_update_unit: a report-queue model predicts every cycle's
// write port, a negedge compare process checks it, and directed scenarios
// pin the model with hand-computed literals.
module tb_btb_update_unit;

  localparam int NUM   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0, res_ready;
  logic [15:0] res_pc = '0, res_target = '0;
  logic        res_taken = 1'b0, res_btb_hit = 1'b0, res_predicted = 1'b0;
  logic        flush_req = 1'b0, busy;
  logic [3:0]  wr_addr;
  logic [10:0] tag_out;
  logic [15:0] bta_out;
  logic        valid_out, predict_out;
  logic        ld_valid, ld_tag, ld_data, ld_predict;

  btb_update_unit #(.num_entries(NUM), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
    .res_btb_hit(res_btb_hit), .res_predicted(res_predicted),
    .flush_req(flush_req), .busy(busy), .wr_addr(wr_addr), .tag_out(tag_out),
    .bta_out(bta_out), .valid_out(valid_out), .predict_out(predict_out),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
    .ld_predict(ld_predict)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- model ----------------
  // exp_q holds accepted reports {pc, target, taken, hit, predicted}.
  logic [34:0] exp_q[$];
  bit          m_live = 0, m_sweep = 0, m_init = 0, m_ready = 0;
  int          m_idx = 0;
  bit          m_lv, m_lt, m_ld, m_lp;
  logic [3:0]  m_addr;
  logic [10:0] m_tag;
  logic [15:0] m_bta;
  logic        m_vo, m_po;

  task automatic m_sweep_write();
    m_lv = 1; m_addr = 4'(m_idx); m_vo = 0;
  endtask

  task automatic m_apply(input logic [34:0] r);
    logic [15:0] pc, tgt;
    logic tk, hit, pr;
    {pc, tgt, tk, hit, pr} = r;
    if (tk && !hit) begin
      m_lv = 1; m_lt = 1; m_ld = 1; m_lp = 1;
      m_addr = pc[4:1]; m_tag = pc[15:5]; m_bta = tgt; m_vo = 1; m_po = 1;
    end else if (hit && (tk != pr)) begin
      m_lp = 1; m_addr = pc[4:1]; m_po = tk;
      if (tk) begin m_ld = 1; m_bta = tgt; end
    end
  endtask

  initial forever begin
    bit acc;
    @(posedge clk);
    acc = res_valid && m_ready;
    {m_lv, m_lt, m_ld, m_lp} = '0;
    if (rst) begin
      m_live = 1; exp_q.delete(); m_sweep = 0; m_idx = 0;
      m_addr = '0; m_tag = '0; m_bta = '0; m_vo = 0; m_po = 0;
`ifdef BTB_UPDATE_RESET_SWEEP_EN
      m_init = 1;
`else
      m_init = 0;
`endif
    end else if (m_sweep) begin
      if (flush_req) begin m_idx = 0; m_sweep_write(); end
      else if (m_idx == NUM - 1) m_sweep = 0;
      else begin m_idx++; m_sweep_write(); end
    end else begin
      if (flush_req || m_init) begin
        exp_q.delete(); acc = 0; m_init = 0;
        m_sweep = 1; m_idx = 0; m_sweep_write();
      end else if (exp_q.size() > 0) begin
        m_apply(exp_q.pop_front());
      end
      if (acc) exp_q.push_back({res_pc, res_target, res_taken, res_btb_hit, res_predicted});
    end
    m_ready = !m_sweep && !m_init && (exp_q.size() < DEPTH);
  end

  // ---------------- scoreboard compare ----------------
  int         n_alloc = 0;
  logic [3:0] alloc_addrs[$];

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("res_ready", res_ready, m_ready);
      check("busy", busy, m_sweep);
      check("strobes", {ld_valid, ld_tag, ld_data, ld_predict}, {m_lv, m_lt, m_ld, m_lp});
      if (m_lv || m_lt || m_ld || m_lp) check("wr_addr", wr_addr, m_addr);
      if (m_lt) check("tag_out", tag_out, m_tag);
      if (m_ld) check("bta_out", bta_out, m_bta);
      if (m_lv) check("valid_out", valid_out, m_vo);
      if (m_lp) check("predict_out", predict_out, m_po);
      if (ld_tag) begin n_alloc++; alloc_addrs.push_back(wr_addr); end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge
  // with res_valid still high.
  task automatic drive(input logic [15:0] pc, input logic [15:0] tgt,
                       input logic tk, input logic hit, input logic pr);
    int g = 0;
    res_valid = 1; res_pc = pc; res_target = tgt;
    res_taken = tk; res_btb_hit = hit; res_predicted = pr;
    while (!res_ready && g < 50) begin @(negedge clk); g++; end
    if (!res_ready) check("accept_timeout", res_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_idx(input logic [3:0] k);
    int g = 0;
    while (!(busy && wr_addr == k) && g < 40) begin @(negedge clk); g++; end
    check("wait_idx", wr_addr, k);
  endtask

  task automatic wait_idle();
    int g = 0;
    repeat (2) @(negedge clk);
    while (busy && g < 40) begin @(negedge clk); g++; end
  endtask

  // Called at the negedge of the first sweep cycle.
  task automatic sweep_check(input string name);
    for (int i = 0; i < NUM; i++) begin
      check({name, "_busy"}, busy, 1);
      check({name, "_addr"}, wr_addr, i);
      check({name, "_strb"}, {ld_valid, ld_tag, ld_data, ld_predict}, 4'b1000);
      check({name, "_vo"}, valid_out, 0);
      check({name, "_rdy"}, res_ready, 0);
      @(negedge clk);
    end
    check({name, "_end_busy"}, busy, 0);
    check({name, "_end_rdy"}, res_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_strb", {ld_valid, ld_tag, ld_data, ld_predict}, 0);
    check("rst_data", {wr_addr, tag_out, bta_out, valid_out, predict_out}, 0);
`ifdef BTB_UPDATE_RESET_SWEEP_EN
    check("rst_ready", res_ready, 0);
    wait_idle();
`else
    check("rst_ready", res_ready, 1);
`endif

    // Alloc: pc 0x1234 -> index 0xA, tag 0x091.
    drive(16'h1234, 16'h1300, 1, 0, 0);
    res_valid = 0;
    @(negedge clk);
    check("alloc_strb", {ld_valid, ld_tag, ld_data, ld_predict}, 4'b1111);
    check("alloc_addr", wr_addr, 4'hA);
    check("alloc_tag", tag_out, 11'h091);
    check("alloc_bta", bta_out, 16'h1300);
    check("alloc_vp", {valid_out, predict_out}, 2'b11);

    // Correct, predicted taken but not taken: only predict bit changes.
    drive(16'h0040, 16'h5555, 0, 1, 1);
    res_valid = 0;
    @(negedge clk);
    check("corr0_strb", {ld_valid, ld_tag, ld_data, ld_predict}, 4'b0001);
    check("corr0_addr", wr_addr, 4'h0);
    check("corr0_po", predict_out, 0);
    check("corr0_bta_held", bta_out, 16'h1300);

    // Correct, predicted not taken but taken: predict + target.
    drive(16'h0046, 16'h2222, 1, 1, 0);
    res_valid = 0;
    @(negedge clk);
    check("corr1_strb", {ld_valid, ld_tag, ld_data, ld_predict}, 4'b0011);
    check("corr1_addr", wr_addr, 4'h3);
    check("corr1_bta", bta_out, 16'h2222);
    check("corr1_po", predict_out, 1);

    // Drops back-to-back: ready never falls, no writes.
    for (int i = 0; i < 6; i++) begin
      check("drop_ready", res_ready, 1);
      drive(16'h0100 + 16'(i * 2), 16'h0, 0, 0, 0);
    end
    // Four allocs back-to-back, indexes 1..4.
    for (int i = 1; i <= 4; i++) drive(16'h2000 + 16'(i * 2), 16'h4000 + 16'(i), 1, 0, 0);
    res_valid = 0;
    repeat (4) @(negedge clk);

    // Flush with reports in flight: none of them may be written.
    drive(16'h3002, 16'h7000, 1, 0, 0);
    flush_req = 1;
    drive(16'h3004, 16'h7004, 1, 0, 0);
    flush_req = 0; res_valid = 0;
    sweep_check("flush");

    // Restart the sweep from index 7.
    flush_req = 1; @(negedge clk); flush_req = 0;
    wait_idx(4'd7);
    flush_req = 1; @(negedge clk); flush_req = 0;
    sweep_check("restart");

    // Reset at index 5 aborts the sweep.
    flush_req = 1; @(negedge clk); flush_req = 0;
    wait_idx(4'd5);
    rst = 1; @(negedge clk); rst = 0;
    check("rst5_busy", busy, 0);
    check("rst5_strb", {ld_valid, ld_tag, ld_data, ld_predict}, 0);
    check("rst5_addr", wr_addr, 0);
`ifdef BTB_UPDATE_RESET_SWEEP_EN
    wait_idle();
`endif
    repeat (3) @(negedge clk);

    // Only the five allocs may ever have written a tag, in order.
    check("alloc_count", n_alloc, 5);
    if (alloc_addrs.size() == 5) begin
      check("alloc_order0", alloc_addrs[0], 4'hA);
      for (int i = 1; i <= 4; i++) check("alloc_order", alloc_addrs[i], i);
    end else begin
      check("alloc_order_len", alloc_addrs.size(), 5);
    end

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule

// File: doc/btb_update_unit.md
Name: btb_update_unit

Overview:
- Write-side controller for the branch target buffer.
- Accepts resolved-branch reports from the execute stage and buffers them in a small FIFO.
- Decides per report whether to allocate an entry, correct an entry, or drop the report.
- Drives the BTB write port (wr_addr, tag/target/valid/predict data, per-array load strobes). It also performs a full-table invalidate sweep on flush.

Parameters:
- num_entries, 16, BTB entry count; must equal the BTB's num_entries; sweep counter width is $clog2(num_entries).
- fifo_depth, 4, resolution FIFO depth (power of 2, minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  resolved-branch report present.
- res_ready  out  1  report accepted when res_valid & res_ready.
- res_pc  in  16  PC of resolved branch (lc3b_word).
- res_target  in  16  computed branch target.
- res_taken  in  1  actual branch outcome.
- res_btb_hit  in  1  fetch saw a BTB hit for this branch.
- res_predicted  in  1  prediction used at fetch (0 if no hit).
- flush_req  in  1  single-cycle request to invalidate the whole BTB.
- busy  out  1  sweep in progress.
- wr_addr  out  4  BTB write index (btb_index).
- tag_out  out  11  tag to write (btb_tag).
- bta_out  out  16  target to write.
- valid_out  out  1  valid bit to write.
- predict_out  out  1  predict bit to write.
- ld_valid, ld_tag, ld_data, ld_predict  out  1 each  BTB array write strobes.

Behaviour:
- Tag = res_pc[15:5], index = res_pc[4:1]. Both are captured into the FIFO at acceptance.
- res_ready = !fifo_full & (state == IDLE). There is no bypass: an accept in cycle N is visible at the FIFO head in cycle N+1.
- In IDLE, with the FIFO non-empty, one head entry is popped per cycle and classified. The resulting write is registered, so strobes are high in cycle N+2 and the BTB is written at the end of cycle N+2.
  - ALLOC (taken & !hit): ld_valid = ld_tag = ld_data = ld_predict = 1; valid_out = 1; predict_out = 1; bta_out = target; tag_out = tag.
  - CORRECT (hit & taken != predicted): ld_predict = 1, predict_out = taken. If taken, ld_data = 1 and bta_out = target as well.
  - DROP (!taken & !hit, or hit with correct prediction): no strobes.
- All strobes are single-cycle and deasserted whenever no write is issued. Data outputs hold their last value when no strobe is active.
- Simultaneous push and pop is allowed in the same cycle when the FIFO is neither full nor empty. When the FIFO is full, res_ready is 0 and the pop frees a slot for the next cycle.
- States: IDLE and SWEEP.
  - IDLE -> SWEEP on flush_req. On that edge the FIFO is cleared (pending reports discarded), any write registered that cycle is cancelled, and the sweep counter is set to 0.
  - SWEEP: each cycle issues ld_valid = 1, valid_out = 0, wr_addr = counter, then increments the counter. After index num_entries-1 is issued, the unit returns to IDLE.
  - A full sweep takes exactly num_entries cycles, with busy high throughout.
- flush_req during SWEEP restarts the counter at 0.
- Reset mid-sweep aborts the sweep and returns the unit to IDLE.
- Reset values: state IDLE, FIFO empty, counter 0, busy 0, all strobes 0, wr_addr/tag_out/bta_out/valid_out/predict_out all 0. res_ready is 1 in the first cycle after reset (unless the optional feature below is enabled).

Optional Feature:
- Macro: BTB_UPDATE_RESET_SWEEP_EN.
- Defined: the cycle after rst deasserts, the unit enters SWEEP automatically. busy = 1 and res_ready = 0 for num_entries cycles, clearing every BTB valid bit so no separate BTB reset is needed.
- Undefined: after reset the unit sits in IDLE; the BTB valid array contents are whatever they were before reset.

Decomposition:
- Shared package lc3b_types:
  - btb_tag (11b) and btb_index (4b), already present.
  - New struct btb_update_req: tag, index, target, taken, hit, predicted.
  - New enum btb_upd_action: DROP, ALLOC, CORRECT.
- Sub-module: btb_update_fifo, a parameterised synchronous FIFO of btb_update_req.
  - Ports: push, pop, clear, full, empty, head.
  - Pointers are one bit wider than the address for the full/empty distinction.

Test Plan:
- Alloc: taken, no hit, res_pc = 0x1234, target = 0x1300 accepted in cycle N. In cycle N+2, all four strobes = 1, wr_addr = 0xA, tag_out = 0x091, bta_out = 0x1300, predict_out = 1.
- Correct: hit, predicted 1, taken 0, pc = 0x0040. Only ld_predict = 1, predict_out = 0, wr_addr = 0x0. Then hit, predicted 0, taken 1 gives ld_predict + ld_data.
- Drop/backpressure (fifo_depth = 4): 6 back-to-back reports with no hit and not taken. No strobes ever; res_ready never drops, because each pop frees a slot. Next, 4 alloc reports: 4 consecutive write cycles in order.
- Flush: 3 reports queued, then flush_req. No writes issue for the queued reports. busy = 1 for 16 cycles, with wr_addr 0..15 and ld_valid = 1, valid_out = 0 each cycle. res_ready = 0 during the sweep, then returns to IDLE.
- Flush restart and reset: flush_req at sweep index 7 restarts the sweep at 0 (16 more cycles). rst at index 5 gives busy = 0 and all strobes 0 on the next cycle. With BTB_UPDATE_RESET_SWEEP_EN, a sweep starts the cycle after reset.
